// File: rtl/prf_read_arbiter.sv
// -----------------------------------------------------------------------------
// prf_read_arbiter
//
// Shares the physical register file read ports among PRF_RR_COUNT read
// requestors. Each bank has two read ports. Every cycle, and independently per
// bank, the first two valid requestors targeting that bank are granted. The
// scan starts at that bank's round-robin pointer and wraps around. Each winning
// request becomes a registered bank-port read command one cycle later.
//
// Ports
//   CLK                             clock
//   RST                             asynchronous, active-high reset
//   req_valid_by_rr                 per-requestor read request
//   req_pr_by_rr                    requested PR, packed by requestor
//   req_ready_by_rr                 combinational grant (transfer = valid & ready)
//   bank_read_valid_by_bank_by_port registered command valid, index bank*2+port
//   bank_read_row_by_bank_by_port   registered bank row (PR upper bits)
//   bank_read_rr_by_bank_by_port    registered id of the granted requestor
//   starve_by_rr                    per-requestor "waiting too long" flag
//                                   (only with PRF_READ_ARB_STARVE_DETECT_EN)
//
// Optional feature: define PRF_READ_ARB_STARVE_DETECT_EN to add per-requestor
// saturating wait counters and the starve_by_rr debug output. Arbitration is
// identical with or without it.
// -----------------------------------------------------------------------------
module prf_read_arbiter #(
    parameter int PR_COUNT            = 128,
    parameter int PRF_BANK_COUNT      = 4,
    parameter int PRF_READ_PORT_COUNT = 2,
    parameter int PRF_RR_COUNT        = 14,
    parameter int STARVE_THRESH       = 16,
    localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
    localparam int LOG_RR             = $clog2(PRF_RR_COUNT),
    localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT,
    localparam int NCMD               = PRF_BANK_COUNT * PRF_READ_PORT_COUNT
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [PRF_RR_COUNT-1:0]          req_valid_by_rr,
    input  logic [PRF_RR_COUNT*LOG_PR_COUNT-1:0] req_pr_by_rr,
    output logic [PRF_RR_COUNT-1:0]          req_ready_by_rr,
    output logic [NCMD-1:0]                  bank_read_valid_by_bank_by_port,
    output logic [NCMD*ROW_W-1:0]            bank_read_row_by_bank_by_port,
    output logic [NCMD*LOG_RR-1:0]           bank_read_rr_by_bank_by_port
`ifdef PRF_READ_ARB_STARVE_DETECT_EN
    ,
    output logic [PRF_RR_COUNT-1:0]          starve_by_rr
`endif
);

    // The grant logic is a fixed first/second pick, and the wait counter is
    // 5 bits wide, so reject configurations the logic cannot honour.
    if (PRF_READ_PORT_COUNT != 2 || STARVE_THRESH < 1 || STARVE_THRESH > 31) begin : g_bad_cfg
        $error("prf_read_arbiter: unsupported PRF_READ_PORT_COUNT or STARVE_THRESH");
    end

    logic [LOG_RR-1:0] rr_ptr_q [PRF_BANK_COUNT];
    logic [LOG_RR-1:0] rr_ptr_d [PRF_BANK_COUNT];

    logic              found0   [PRF_BANK_COUNT];
    logic              found1   [PRF_BANK_COUNT];
    logic [LOG_RR-1:0] win0     [PRF_BANK_COUNT];
    logic [LOG_RR-1:0] win1     [PRF_BANK_COUNT];

    logic [NCMD-1:0]        read_valid_q, read_valid_d;
    logic [NCMD*ROW_W-1:0]  read_row_q,   read_row_d;
    logic [NCMD*LOG_RR-1:0] read_rr_q,    read_rr_d;

    function automatic int scan_index(input int start, input int offset);
        int s;
        s = start + offset;
        return (s >= PRF_RR_COUNT) ? s - PRF_RR_COUNT : s;
    endfunction

    function automatic logic [LOG_RR-1:0] ptr_after(input logic [LOG_RR-1:0] idx);
        return (idx == LOG_RR'(PRF_RR_COUNT - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Per-bank circular scan: first eligible -> port 0, second -> port 1.
    always_comb begin
        int ptr_eff;
        int idx;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            found0[b] = 1'b0;
            found1[b] = 1'b0;
            win0[b]   = '0;
            win1[b]   = '0;
            // Out-of-range pointers cannot occur normally; scan from 0 if forced.
            ptr_eff = (int'(rr_ptr_q[b]) >= PRF_RR_COUNT) ? 0 : int'(rr_ptr_q[b]);
            for (int k = 0; k < PRF_RR_COUNT; k++) begin
                idx = scan_index(ptr_eff, k);
                if (req_valid_by_rr[idx] &&
                    req_pr_by_rr[idx*LOG_PR_COUNT +: LOG_PRF_BANK_COUNT] == LOG_PRF_BANK_COUNT'(b)) begin
                    if (!found0[b]) begin
                        found0[b] = 1'b1;
                        win0[b]   = LOG_RR'(idx);
                    end else if (!found1[b]) begin
                        found1[b] = 1'b1;
                        win1[b]   = LOG_RR'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready_by_rr = '0;
        read_valid_d    = '0;
        read_row_d      = read_row_q;
        read_rr_d       = read_rr_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            rr_ptr_d[b] = rr_ptr_q[b];
            if (found0[b]) begin
                // RST gates ready so nothing transfers while the arbiter is held in reset.
                req_ready_by_rr[win0[b]]             = !RST;
                read_valid_d[b*2]                    = 1'b1;
                read_row_d[(b*2)*ROW_W +: ROW_W]     =
                    req_pr_by_rr[int'(win0[b])*LOG_PR_COUNT + LOG_PRF_BANK_COUNT +: ROW_W];
                read_rr_d[(b*2)*LOG_RR +: LOG_RR]    = win0[b];
                rr_ptr_d[b]                          = ptr_after(win0[b]);
            end
            if (found1[b]) begin
                req_ready_by_rr[win1[b]]             = !RST;
                read_valid_d[b*2+1]                  = 1'b1;
                read_row_d[(b*2+1)*ROW_W +: ROW_W]   =
                    req_pr_by_rr[int'(win1[b])*LOG_PR_COUNT + LOG_PRF_BANK_COUNT +: ROW_W];
                read_rr_d[(b*2+1)*LOG_RR +: LOG_RR]  = win1[b];
                rr_ptr_d[b]                          = ptr_after(win1[b]);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            read_valid_q <= '0;
            read_row_q   <= '0;
            read_rr_q    <= '0;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                rr_ptr_q[b] <= '0;
            end
        end else begin
            read_valid_q <= read_valid_d;
            read_row_q   <= read_row_d;
            read_rr_q    <= read_rr_d;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
            end
        end
    end

    assign bank_read_valid_by_bank_by_port = read_valid_q;
    assign bank_read_row_by_bank_by_port   = read_row_q;
    assign bank_read_rr_by_bank_by_port    = read_rr_q;

`ifdef PRF_READ_ARB_STARVE_DETECT_EN
    logic [4:0]              wait_cnt_q [PRF_RR_COUNT];
    logic [4:0]              wait_cnt_d [PRF_RR_COUNT];
    logic [PRF_RR_COUNT-1:0] starve_q, starve_d;

    // The flag is taken from the next count so it clears one cycle after the transfer.
    always_comb begin
        for (int i = 0; i < PRF_RR_COUNT; i++) begin
            if (!req_valid_by_rr[i] || req_ready_by_rr[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != 5'h1f) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 5'd1;
            end else begin
                wait_cnt_d[i] = wait_cnt_q[i];
            end
            starve_d[i] = (int'(wait_cnt_d[i]) >= STARVE_THRESH);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_q <= '0;
            for (int i = 0; i < PRF_RR_COUNT; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            starve_q <= starve_d;
            for (int i = 0; i < PRF_RR_COUNT; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign starve_by_rr = starve_q;
`endif

endmodule
